// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sizing constants, FSM encoding, round constants
// and the GF(2^8) helpers used by the cipher data path.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned NB = 4;
  localparam int unsigned KW = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Round constant for rounds 1..10; zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; byte 0 of the column sits in the MSBs.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, shared by the data path and key expansion.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_c
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 occupies the MSBs, so the bit offset of entry a is (255-a)*8.
  assign s_c = SBOX_TBL[{~a_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher_top.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion.
// Optional AES_ENC_LAST_KEY_OUT_EN adds a registered round-10 key output (last_key).
module aes_cipher_top #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kld,
  input  logic          ld,
  input  logic [KW-1:0] key,
  input  logic [KW-1:0] text_in,
  output logic          done,
  output logic          busy,
  output logic [KW-1:0] text_out
`ifdef AES_ENC_LAST_KEY_OUT_EN
  ,
  output logic [KW-1:0] last_key
`endif
);

  import aes_pkg::*;

  localparam int unsigned WW = aes_pkg::KW / aes_pkg::NB;

  if (NR != aes_pkg::NR || KW != aes_pkg::KW) begin : g_bad_cfg
    $error("aes_cipher_top supports only AES-128 (NR=10, KW=128)");
  end

  logic [1:0]    fsm_q, fsm_d;
  logic [3:0]    rcnt_q, rcnt_d;
  logic [KW-1:0] key_q, key_d;
  logic [KW-1:0] rk_q, rk_d;
  logic [KW-1:0] st_q, st_d;
  logic [KW-1:0] out_q, out_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [KW-1:0] lk_q, lk_d;
`endif

  logic [KW-1:0] k0_c;
  logic [KW-1:0] sb_c, sr_c, mc_c, nk_c;
  logic [WW-1:0] rot_c, sw_c, w0_c, w1_c, w2_c, w3_c;

  // SubBytes, ShiftRows and MixColumns on the current state.
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a_i(st_q[127-8*i -: 8]), .s_c(sb_c[127-8*i -: 8]));
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr_c[127-8*(r+4*c) -: 8] = sb_c[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign mc_c[127-32*c -: 32] = mix_column(sr_c[127-32*c -: 32]);
  end

  // Next round key from the working key and rcon[rcnt].
  assign rot_c = {rk_q[23:0], rk_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_ksb
    aes_sbox u_sbox (.a_i(rot_c[31-8*i -: 8]), .s_c(sw_c[31-8*i -: 8]));
  end

  assign w0_c = rk_q[127:96] ^ sw_c ^ {rcon(rcnt_q), 24'h000000};
  assign w1_c = rk_q[95:64] ^ w0_c;
  assign w2_c = rk_q[63:32] ^ w1_c;
  assign w3_c = rk_q[31:0]  ^ w2_c;
  assign nk_c = {w0_c, w1_c, w2_c, w3_c};

  assign k0_c = kld ? key : key_q;

  always_comb begin
    fsm_d  = fsm_q;
    rcnt_d = rcnt_q;
    key_d  = key_q;
    rk_d   = rk_q;
    st_d   = st_q;
    out_d  = out_q;
    done_d = 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    lk_d   = lk_q;
`endif
    if (kld) begin
      key_d = key;
    end
    unique case (fsm_q)
      ST_IDLE: begin
        if (ld) begin
          st_d   = text_in ^ k0_c;
          rk_d   = k0_c;
          rcnt_d = 4'd1;
          fsm_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        rk_d   = nk_c;
        rcnt_d = rcnt_q + 4'd1;
        if (rcnt_q == 4'(NR)) begin
          st_d  = sr_c ^ nk_c;
          fsm_d = ST_DONE;
        end else begin
          st_d  = mc_c ^ nk_c;
        end
      end
      ST_DONE: begin
        out_d  = st_q;
        done_d = 1'b1;
        rcnt_d = 4'd0;
        fsm_d  = ST_IDLE;
`ifdef AES_ENC_LAST_KEY_OUT_EN
        lk_d   = rk_q;
`endif
      end
      default: begin
        fsm_d  = ST_IDLE;
        rcnt_d = 4'd0;
      end
    endcase
    busy_d = (fsm_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= ST_IDLE;
      rcnt_q <= 4'd0;
      key_q  <= '0;
      rk_q   <= '0;
      st_q   <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
      lk_q   <= '0;
`endif
    end else begin
      fsm_q  <= fsm_d;
      rcnt_q <= rcnt_d;
      key_q  <= key_d;
      rk_q   <= rk_d;
      st_q   <= st_d;
      out_q  <= out_d;
      done_q <= done_d;
      busy_q <= busy_d;
`ifdef AES_ENC_LAST_KEY_OUT_EN
      lk_q   <= lk_d;
`endif
    end
  end

  assign done     = done_q;
  assign busy     = busy_q;
  assign text_out = out_q;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  assign last_key = lk_q;
`endif

endmodule

// File: tb/tb_aes_cipher_top.sv
// Self-checking bench for aes_cipher_top: known-answer table, random blocks
// against a byte-level AES model, and handshake corner sequences.
module tb_aes_cipher_top;

  logic         clk;
  logic         rst;
  logic         kld;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic         done;
  logic         busy;
  logic [127:0] text_out;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [127:0] last_key;
`endif

  int           n_cmp;
  int           n_err;
  logic [127:0] key_reg_m;
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];

  typedef struct {
    bit           use_kld;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] lk;
  } vec_t;

  vec_t vecs [3];

  aes_cipher_top dut (
    .clk      (clk),
    .rst      (rst),
    .kld      (kld),
    .ld       (ld),
    .key      (key),
    .text_in  (text_in),
    .done     (done),
    .busy     (busy),
    .text_out (text_out)
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    .last_key (last_key)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (FIPS-197 arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int rnd);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ round_key(k, 0);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      v = v ^ round_key(k, rnd);
    end
    return v;
  endfunction

  // Inverse cipher, standing in for the decrypt core in the round-trip check.
  function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = ct ^ round_key(k, 10);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*((c+r)%4)] = v[127-8*(r+4*c) -: 8];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = isb[t[i]];
      v = v ^ round_key(k, rnd);
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = v[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(8'h0e, t[4*c]) ^ gmul(8'h0b, t[4*c+1]) ^ gmul(8'h0d, t[4*c+2]) ^ gmul(8'h09, t[4*c+3]);
          s[4*c+1] = gmul(8'h09, t[4*c]) ^ gmul(8'h0e, t[4*c+1]) ^ gmul(8'h0b, t[4*c+2]) ^ gmul(8'h0d, t[4*c+3]);
          s[4*c+2] = gmul(8'h0d, t[4*c]) ^ gmul(8'h09, t[4*c+1]) ^ gmul(8'h0e, t[4*c+2]) ^ gmul(8'h0b, t[4*c+3]);
          s[4*c+3] = gmul(8'h0b, t[4*c]) ^ gmul(8'h0d, t[4*c+1]) ^ gmul(8'h09, t[4*c+2]) ^ gmul(8'h0e, t[4*c+3]);
        end
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_done(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  // Loads one block at the current negedge and returns at the negedge where done shows.
  task automatic run_block(input bit use_kld, input logic [127:0] k, input logic [127:0] pt,
                           input logic [127:0] exp_ct, input logic [127:0] exp_lk,
                           input string tag, output logic [127:0] ct);
    int cyc;
    if (use_kld) key_reg_m = k;
    kld     = use_kld;
    key     = k;
    ld      = 1'b1;
    text_in = pt;
    @(negedge clk);
    kld     = 1'b0;
    ld      = 1'b0;
    key     = rand128();
    text_in = rand128();
    check({tag, " busy after load"}, 128'(busy), 128'(1));
    check({tag, " done low after load"}, 128'(done), 128'(0));
    wait_done(1, cyc);
    check({tag, " latency"}, 128'(cyc), 128'(12));
    check({tag, " text_out"}, text_out, exp_ct);
    check({tag, " busy in done cycle"}, 128'(busy), 128'(0));
`ifdef AES_ENC_LAST_KEY_OUT_EN
    check({tag, " last_key"}, last_key, exp_lk);
`endif
    ct = text_out;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] ct;
    logic [127:0] ka;
    logic [127:0] kb;
    logic [127:0] pt;
    logic [127:0] kused;
    bit           uk;
    int           cyc;
    int           cnt;

    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) sb[i] = calc_sbox(8'(i));
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

    rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0; key_reg_m = '0;
    repeat (3) @(negedge clk);
    check("reset done", 128'(done), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    check("reset text_out", text_out, 128'h0);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    check("reset last_key", last_key, 128'h0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Known answers, run back to back (each load lands on the edge after done).
    vecs[0] = '{1'b1, 128'h0, 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[1] = '{1'b0, 128'hdeadbeef_00000000_00000000_cafef00d, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                128'hf795bd4a52e29ed713d313fa20e98dbc, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[2] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    for (int i = 0; i < 3; i++) begin
      kused = vecs[i].use_kld ? vecs[i].key : key_reg_m;
      run_block(vecs[i].use_kld, vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].lk,
                $sformatf("kat%0d", i), ct);
      check($sformatf("kat%0d decrypt round trip", i), ref_dec(kused, ct), vecs[i].pt);
    end

    // Random blocks, with and without a fresh key load.
    for (int i = 0; i < 6; i++) begin
      uk    = 1'($urandom_range(0, 1));
      ka    = rand128();
      pt    = rand128();
      kused = uk ? ka : key_reg_m;
      run_block(uk, ka, pt, ref_enc(kused, pt), round_key(kused, 10), $sformatf("rnd%0d", i), ct);
      check($sformatf("rnd%0d decrypt round trip", i), ref_dec(kused, ct), pt);
    end

    // ld pulsed while busy must be ignored.
    ka = rand128(); pt = rand128(); key_reg_m = ka;
    kld = 1'b1; key = ka; ld = 1'b1; text_in = pt;
    @(negedge clk);
    kld = 1'b0; ld = 1'b0;
    repeat (4) @(negedge clk);
    ld = 1'b1; text_in = rand128();
    @(negedge clk);
    ld = 1'b0;
    wait_done(6, cyc);
    check("ld while busy latency", 128'(cyc), 128'(12));
    check("ld while busy text_out", text_out, ref_enc(ka, pt));
    count_done(20, cnt);
    check("ld while busy extra done", 128'(cnt), 128'(0));
    check("ld while busy text_out held", text_out, ref_enc(ka, pt));

    // kld mid-block: current block keeps its key, next block uses the new one.
    ka = rand128(); kb = rand128(); pt = rand128(); key_reg_m = ka;
    kld = 1'b1; key = ka; ld = 1'b1; text_in = pt;
    @(negedge clk);
    kld = 1'b0; ld = 1'b0;
    repeat (3) @(negedge clk);
    kld = 1'b1; key = kb;
    @(negedge clk);
    kld = 1'b0; key = rand128(); key_reg_m = kb;
    wait_done(5, cyc);
    check("kld mid-block latency", 128'(cyc), 128'(12));
    check("kld mid-block text_out", text_out, ref_enc(ka, pt));
    pt = rand128();
    run_block(1'b0, rand128(), pt, ref_enc(kb, pt), round_key(kb, 10), "after kld", ct);

    // Reset mid-block aborts; the key register returns to zero.
    ka = rand128(); pt = rand128();
    kld = 1'b1; key = ka; ld = 1'b1; text_in = pt;
    @(negedge clk);
    kld = 1'b0; ld = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort done", 128'(done), 128'(0));
    check("abort busy", 128'(busy), 128'(0));
    check("abort text_out", text_out, 128'h0);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    check("abort last_key", last_key, 128'h0);
`endif
    rst = 1'b1; key_reg_m = '0;
    count_done(15, cnt);
    check("abort no done", 128'(cnt), 128'(0));
    pt = rand128();
    run_block(1'b0, rand128(), pt, ref_enc(128'h0, pt), round_key(128'h0, 10), "after abort", ct);
    @(negedge clk);
    check("final done width", 128'(done), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
